// File: rtl/mmu_ctrl.sv
// Bus address decoder and cycle controller: programmable region table,
// wait-state sequencing, and unmapped / write-protect fault reporting.
module mmu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int NREGIONS   = 8,
    parameter int CS_WIDTH   = 4,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              read,
    input  logic                              write,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic                              map,
    input  logic                              cfg_we,
    input  logic [$clog2(NREGIONS)-1:0]       cfg_idx,
    input  logic [ADDR_WIDTH-1:0]             cfg_base,
    input  logic [ADDR_WIDTH-1:0]             cfg_limit,
    input  logic [CS_WIDTH+WAIT_WIDTH+2:0]    cfg_attr,
    output logic [CS_WIDTH-1:0]               chipselect,
    output logic                              start,
    output logic                              buswrite,
    output logic                              buswait,
    output logic                              busfault,
    output logic [1:0]                        fault_cause
);

    localparam int IDX_W   = $clog2(NREGIONS);
    localparam int ATTR_W  = CS_WIDTH + WAIT_WIDTH + 3;
    localparam int WP_BIT  = CS_WIDTH + WAIT_WIDTH;
    localparam int MODE_LO = WP_BIT + 1;

    localparam logic [ADDR_WIDTH-1:0] BASE0  = ADDR_WIDTH'(32'hF000_0000);
    localparam logic [ADDR_WIDTH-1:0] LIMIT0 = {ADDR_WIDTH{1'b1}};
    localparam logic [ATTR_W-1:0]     ATTR0  = {2'b11, 1'b0, WAIT_WIDTH'(32'd3), CS_WIDTH'(32'd8)};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PRE   = 3'd2,
        ST_POST  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    logic [ADDR_WIDTH-1:0] base_r  [NREGIONS];
    logic [ADDR_WIDTH-1:0] limit_r [NREGIONS];
    logic [ATTR_W-1:0]     attr_r  [NREGIONS];

    logic [NREGIONS-1:0]   hit_vec_s;
    logic [IDX_W-1:0]      hit_idx_s;
    logic                  hit_s;
    logic                  req_s;

    state_t                state_r, state_next_s;
    logic [WAIT_WIDTH-1:0] cnt_r, cnt_next_s;
    logic [WAIT_WIDTH-1:0] waits_r, waits_next_s;
    logic [CS_WIDTH-1:0]   cs_r, cs_next_s;
    logic [1:0]            cause_r, cause_next_s;

    logic [CS_WIDTH-1:0]   chipselect_next_s;
    logic                  start_next_s, buswrite_next_s, buswait_next_s, busfault_next_s;
    logic [CS_WIDTH-1:0]   chipselect_r;
    logic                  start_r, buswrite_r, buswait_r, busfault_r;

    assign req_s = read | write;

    // Region table storage; entry 0 comes out of reset as the boot window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGIONS; i++) begin
                base_r[i]  <= (i == 0) ? BASE0  : '0;
                limit_r[i] <= (i == 0) ? LIMIT0 : '0;
                attr_r[i]  <= (i == 0) ? ATTR0  : '0;
            end
        end else if (cfg_we) begin
            base_r[cfg_idx]  <= cfg_base;
            limit_r[cfg_idx] <= cfg_limit;
            attr_r[cfg_idx]  <= cfg_attr;
        end
    end

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_vec_s = '0;
        for (int i = 0; i < NREGIONS; i++) begin
            hit_vec_s[i] = (address >= base_r[i]) && (address <= limit_r[i]) &&
                           (map ? attr_r[i][MODE_LO+1] : attr_r[i][MODE_LO]);
        end
        hit_idx_s = '0;
        for (int i = NREGIONS - 1; i >= 0; i--) begin
            hit_idx_s = hit_vec_s[i] ? IDX_W'(i) : hit_idx_s;
        end
        hit_s = |hit_vec_s;
    end

    // Next-state logic; cs and waits are captured only when leaving IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        waits_next_s = waits_r;
        cs_next_s    = cs_r;
        cause_next_s = cause_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (!hit_s) begin
                        state_next_s = ST_FAULT;
                        cause_next_s = 2'b01;
                    end else if (attr_r[hit_idx_s][WP_BIT] && write) begin
                        state_next_s = ST_FAULT;
                        cause_next_s = 2'b10;
                    end else begin
                        state_next_s = ST_START;
                        cs_next_s    = attr_r[hit_idx_s][CS_WIDTH-1:0];
                        waits_next_s = attr_r[hit_idx_s][WP_BIT-1:CS_WIDTH];
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (req_s) begin
                    state_next_s = ST_PRE;
                    cnt_next_s   = waits_r;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (cnt_r == WAIT_WIDTH'(32'd0)) begin
                    state_next_s = ST_POST;
                end else begin
                    cnt_next_s = cnt_r - WAIT_WIDTH'(32'd1);
                end
            end
            ST_POST: begin
                if (!req_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_POST;
                end
            end
            ST_FAULT: begin
                if (!req_s) begin
                    state_next_s = ST_IDLE;
                    cause_next_s = 2'b00;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cause_next_s = 2'b00;
            end
        endcase
    end

    // Output values for the upcoming state, registered below.
    always_comb begin
        chipselect_next_s = '0;
        start_next_s      = 1'b0;
        buswrite_next_s   = 1'b0;
        buswait_next_s    = 1'b0;
        busfault_next_s   = 1'b0;
        case (state_next_s)
            ST_START: begin
                start_next_s      = 1'b1;
                buswait_next_s    = 1'b1;
                chipselect_next_s = cs_next_s;
            end
            ST_PRE: begin
                buswait_next_s    = 1'b1;
                buswrite_next_s   = write;
                chipselect_next_s = cs_next_s;
            end
            ST_POST: begin
                chipselect_next_s = cs_next_s;
            end
            ST_FAULT: begin
                busfault_next_s = 1'b1;
            end
            default: begin
                buswait_next_s = 1'b1;
            end
        endcase
    end

    // State, counter, latched entry fields and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            waits_r      <= '0;
            cs_r         <= '0;
            cause_r      <= 2'b00;
            chipselect_r <= '0;
            start_r      <= 1'b0;
            buswrite_r   <= 1'b0;
            buswait_r    <= 1'b1;
            busfault_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            waits_r      <= waits_next_s;
            cs_r         <= cs_next_s;
            cause_r      <= cause_next_s;
            chipselect_r <= chipselect_next_s;
            start_r      <= start_next_s;
            buswrite_r   <= buswrite_next_s;
            buswait_r    <= buswait_next_s;
            busfault_r   <= busfault_next_s;
        end
    end

    assign chipselect  = chipselect_r;
    assign start       = start_r;
    assign buswrite    = buswrite_r;
    assign buswait     = buswait_r;
    assign busfault    = busfault_r;
    assign fault_cause = cause_r;

endmodule

// File: tb/tb_mmu_ctrl.sv
// Self-checking bench for mmu_ctrl: directed vector table, multi-cycle corner
// sequences, and random transactions against a transaction-level region model.
module tb_mmu_ctrl;

    logic        clock = 1'b0;
    logic        reset, read, write, map, cfg_we;
    logic [31:0] address, cfg_base, cfg_limit;
    logic [2:0]  cfg_idx;
    logic [10:0] cfg_attr;
    logic [3:0]  chipselect;
    logic        start, buswrite, buswait, busfault;
    logic [1:0]  fault_cause;

    int n_err = 0;
    int n_checks = 0;

    logic [31:0] m_base  [8];
    logic [31:0] m_limit [8];
    logic [10:0] m_attr  [8];

    typedef struct {
        bit          prog;
        int          idx;
        logic [31:0] base;
        logic [31:0] limit;
        logic [10:0] attr;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        bit          mp;
        bit          ef;
        logic [1:0]  ec;
        logic [3:0]  ecs;
        int          ew;
    } vec_t;
    vec_t tbl[$];

    mmu_ctrl dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .map(map), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_attr(cfg_attr),
        .chipselect(chipselect), .start(start), .buswrite(buswrite),
        .buswait(buswait), .busfault(busfault), .fault_cause(fault_cause)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] mk_attr(input logic [1:0] mode, input logic wp,
                                            input logic [3:0] w, input logic [3:0] cs);
        return {mode, wp, w, cs};
    endfunction

    function automatic logic [9:0] vec(input logic [3:0] cs, input logic st, input logic bw,
                                       input logic wt, input logic bf, input logic [1:0] fc);
        return {cs, st, bw, wt, bf, fc};
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {chipselect, start, buswrite, buswait, busfault, fault_cause};
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got cs/st/bw/wt/bf/fc=%b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_base[i] = 32'h0; m_limit[i] = 32'h0; m_attr[i] = 11'h0;
        end
        m_base[0]  = 32'hF000_0000;
        m_limit[0] = 32'hFFFF_FFFF;
        m_attr[0]  = mk_attr(2'b11, 1'b0, 4'd3, 4'd8);
    endtask

    // First matching entry in index order wins; a hit with wp blocks writes.
    task automatic model_decode(input logic [31:0] addr, input bit mp, input bit wr,
                                output bit f, output logic [1:0] c,
                                output logic [3:0] cs, output int w);
        bit hit;
        hit = 1'b0; f = 1'b0; c = 2'd0; cs = 4'd0; w = 0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && m_base[i] <= addr && addr <= m_limit[i] && m_attr[i][9 + int'(mp)]) begin
                hit = 1'b1;
                cs  = m_attr[i][3:0];
                w   = int'(m_attr[i][7:4]);
                if (m_attr[i][8] && wr) begin
                    f = 1'b1; c = 2'd2;
                end
            end
        end
        if (!hit) begin
            f = 1'b1; c = 2'd1;
        end
    endtask

    task automatic prog_entry(input int idx, input logic [31:0] b, input logic [31:0] l,
                              input logic [10:0] a);
        cfg_idx = idx[2:0]; cfg_base = b; cfg_limit = l; cfg_attr = a; cfg_we = 1'b1;
        @(posedge clock); #1;
        cfg_we = 1'b0;
        m_base[idx] = b; m_limit[idx] = l; m_attr[idx] = a;
    endtask

    // One complete bus cycle; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input bit mp,
                           input bit ef, input logic [1:0] ec, input logic [3:0] ecs,
                           input int ew, input string nm);
        read = rd; write = wr; address = addr; map = mp;
        @(posedge clock); #1;
        if (ef) begin
            check({nm, "_fault"}, vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, ec));
            @(posedge clock); #1;
            check({nm, "_fhold"}, vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, ec));
        end else begin
            check({nm, "_start"}, vec(ecs, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
            for (int j = 0; j <= ew; j++) begin
                @(posedge clock); #1;
                check($sformatf("%s_pre%0d", nm, j), vec(ecs, 1'b0, wr, 1'b1, 1'b0, 2'd0));
            end
            @(posedge clock); #1;
            check({nm, "_post"}, vec(ecs, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
            @(posedge clock); #1;
            check({nm, "_phold"}, vec(ecs, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        end
        read = 1'b0; write = 1'b0;
        @(posedge clock); #1;
        check({nm, "_idle"}, vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    endtask

    task automatic run_model_txn(input bit rd, input bit wr, input logic [31:0] addr,
                                 input bit mp, input string nm);
        bit f; logic [1:0] c; logic [3:0] cs; int w;
        model_decode(addr, mp, wr, f, c, cs, w);
        run_txn(rd, wr, addr, mp, f, c, cs, w, nm);
    endtask

    function automatic void add_txn(input bit rd, input bit wr, input logic [31:0] addr,
                                    input bit mp, input bit ef, input logic [1:0] ec,
                                    input logic [3:0] ecs, input int ew);
        vec_t v;
        v = '{default: 0};
        v.rd = rd; v.wr = wr; v.addr = addr; v.mp = mp;
        v.ef = ef; v.ec = ec; v.ecs = ecs; v.ew = ew;
        tbl.push_back(v);
    endfunction

    function automatic void add_prog(input int idx, input logic [31:0] b,
                                     input logic [31:0] l, input logic [10:0] a);
        vec_t v;
        v = '{default: 0};
        v.prog = 1'b1; v.idx = idx; v.base = b; v.limit = l; v.attr = a;
        tbl.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; map = 1'b0; address = 32'h0;
        cfg_we = 1'b0; cfg_idx = 3'd0; cfg_base = 32'h0; cfg_limit = 32'h0; cfg_attr = 11'h0;
        model_reset();

        add_txn(1, 0, 32'hFFFF_0000, 0, 0, 2'd0, 4'd8, 3);
        add_txn(1, 0, 32'h0010_0000, 0, 1, 2'd1, 4'd0, 0);
        add_txn(0, 1, 32'hFFFF_0000, 1, 0, 2'd0, 4'd8, 3);
        add_prog(1, 32'h0000_0000, 32'h003F_FFFF, mk_attr(2'b01, 1'b1, 4'd0, 4'd6));
        add_txn(0, 1, 32'h0000_0010, 0, 1, 2'd2, 4'd0, 0);
        add_txn(1, 1, 32'h0000_0010, 0, 1, 2'd2, 4'd0, 0);
        add_txn(1, 0, 32'h0000_0010, 0, 0, 2'd0, 4'd6, 0);
        add_txn(1, 0, 32'h0000_0010, 1, 1, 2'd1, 4'd0, 0);
        add_txn(1, 0, 32'h003F_FFFF, 0, 0, 2'd0, 4'd6, 0);
        add_txn(1, 0, 32'h0040_0000, 0, 1, 2'd1, 4'd0, 0);
        add_prog(1, 32'h0070_0000, 32'h008F_FFFF, mk_attr(2'b11, 1'b0, 4'd1, 4'd5));
        add_prog(2, 32'h0080_0000, 32'h00FF_FFFF, mk_attr(2'b11, 1'b0, 4'd2, 4'd4));
        add_prog(3, 32'h0200_0000, 32'h0100_0000, mk_attr(2'b11, 1'b0, 4'd0, 4'd3));
        add_txn(1, 0, 32'h0080_0000, 0, 0, 2'd0, 4'd5, 1);
        add_txn(0, 1, 32'h0090_0000, 1, 0, 2'd0, 4'd4, 2);
        add_txn(1, 0, 32'h00FF_FFFF, 0, 0, 2'd0, 4'd4, 2);
        add_txn(1, 0, 32'h0180_0000, 0, 1, 2'd1, 4'd0, 0);
        add_txn(1, 0, 32'hEFFF_FFFF, 0, 1, 2'd1, 4'd0, 0);
        add_txn(1, 0, 32'hF000_0000, 0, 0, 2'd0, 4'd8, 3);
        add_prog(4, 32'h0000_0000, 32'hFFFF_FFFF, mk_attr(2'b00, 1'b0, 4'd0, 4'd2));
        add_txn(1, 0, 32'h0000_0000, 0, 1, 2'd1, 4'd0, 0);

        #1;
        check("reset_state", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_reset", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].prog) begin
                prog_entry(tbl[k].idx, tbl[k].base, tbl[k].limit, tbl[k].attr);
            end else begin
                run_txn(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].mp, tbl[k].ef,
                        tbl[k].ec, tbl[k].ecs, tbl[k].ew, $sformatf("tbl%0d", k));
            end
        end

        // Request dropped in START returns straight to IDLE.
        read = 1'b1; address = 32'hFFFF_0000; map = 1'b0;
        @(posedge clock); #1;
        check("dropstart_start", vec(4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        read = 1'b0;
        @(posedge clock); #1;
        check("dropstart_idle", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));

        // Request dropped in PRE still runs the full wait count into POST.
        read = 1'b1;
        @(posedge clock); #1;
        check("droppre_start", vec(4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        @(posedge clock); #1;
        check("droppre_pre0", vec(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        read = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clock); #1;
            check($sformatf("droppre_pre%0d", j), vec(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        end
        @(posedge clock); #1;
        check("droppre_post", vec(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        @(posedge clock); #1;
        check("droppre_idle", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));

        // Table rewrite of the active entry mid-cycle leaves the cycle untouched.
        read = 1'b1; address = 32'h0080_0000;
        @(posedge clock); #1;
        check("midcfg_start", vec(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        prog_entry(1, 32'h0070_0000, 32'h008F_FFFF, mk_attr(2'b11, 1'b0, 4'd0, 4'd7));
        check("midcfg_pre0", vec(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        @(posedge clock); #1;
        check("midcfg_pre1", vec(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        @(posedge clock); #1;
        check("midcfg_post", vec(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        read = 1'b0;
        @(posedge clock); #1;
        check("midcfg_idle", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        run_model_txn(1'b1, 1'b0, 32'h0080_0000, 1'b0, "midcfg_next");

        // Asynchronous reset in the middle of PRE.
        write = 1'b1; address = 32'hF000_0100; map = 1'b0;
        @(posedge clock); #1;
        check("rstpre_start", vec(4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        @(posedge clock); #1;
        check("rstpre_pre", vec(4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        #2 reset = 1'b1;
        #1;
        check("rstpre_async", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        write = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        check("rstpre_idle", vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        run_txn(1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, 2'd0, 4'd8, 3, "rstpre_after");
        run_model_txn(1'b1, 1'b0, 32'h0000_0040, 1'b0, "rstpre_cleared");

        // Random table programming and bus cycles against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [31:0] b, l;
                b = 32'($urandom_range(0, 31)) << 20;
                l = b + (32'($urandom_range(0, 4)) << 20) - 32'd1;
                prog_entry(int'($urandom_range(0, 7)), b, l,
                           mk_attr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
            end
            begin
                logic [31:0] a;
                int k;
                k = int'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) begin
                    a = 32'hF000_0000 + 32'($urandom_range(0, 65535));
                end else begin
                    a = (32'($urandom_range(0, 35)) << 20) |
                        (($urandom_range(0, 1) == 1) ? 32'h000F_FFFF : 32'h0);
                end
                run_model_txn(k[0], k[1], a, 1'($urandom_range(0, 1)),
                              $sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mmu_ctrl.md
MMU_CTRL -- requirements
Module: mmu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter NREGIONS, default 8, number of programmable decode regions (power of 2, >=2).
REQ-003 SHALL have parameter CS_WIDTH, default 4, chip-select code width.
REQ-004 SHALL have parameter WAIT_WIDTH, default 4, per-region wait-state count width.
REQ-005 SHALL have ports:
  clock  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  read  in  1  bus read request, held until cycle ends
  write  in  1  bus write request, held until cycle ends
  address  in  ADDR_WIDTH  request address
  map  in  1  memory-map mode select
  cfg_we  in  1  region-table write strobe
  cfg_idx  in  log2(NREGIONS)  region entry index
  cfg_base  in  ADDR_WIDTH  region first address, inclusive
  cfg_limit  in  ADDR_WIDTH  region last address, inclusive
  cfg_attr  in  CS_WIDTH+WAIT_WIDTH+3  {mode[1:0], wp, waits, cs}
  chipselect  out  CS_WIDTH  selected device code
  start  out  1  address-latch phase
  buswrite  out  1  write strobe to device
  buswait  out  1  stall to master; 0 = cycle complete
  busfault  out  1  access fault indication
  fault_cause  out  2  00 none, 01 unmapped, 10 write-protect
REQ-006 SHALL implement one clock domain; reset asynchronous, active-high.

Function
REQ-007 Region hit SHALL require base<=address<=limit (unsigned) and mode match: mode bit0 enables map=0, bit1 enables map=1; mode=00 disables the entry.
REQ-008 Multiple hits SHALL resolve to the lowest index; base>limit SHALL never hit.
REQ-009 A write with read and write both high SHALL be treated as a write.
REQ-010 States SHALL be IDLE, START, PRE, POST, FAULT.
REQ-011 IDLE: on read|write, no hit -> FAULT with cause 01; hit with wp=1 and write -> FAULT with cause 10; otherwise -> START, latching cs and waits of the hit entry.
REQ-012 START: start=1; request still high -> PRE with wait counter loaded from latched waits; request dropped -> IDLE.
REQ-013 PRE: buswrite=write; counter SHALL decrement each cycle; transition to POST on the cycle the counter is 0, so PRE lasts waits+1 cycles.
REQ-014 POST: buswait=0; hold until read and write are both low, then -> IDLE.
REQ-015 FAULT: busfault=1, buswait=0, fault_cause held; hold until request drops, then -> IDLE with fault_cause cleared.
REQ-016 buswait SHALL be 1 in IDLE, START and PRE.
REQ-017 chipselect SHALL be 0 in IDLE and FAULT and the latched cs in START, PRE and POST.
REQ-018 A cfg_we write SHALL update the entry at the clock edge and affect decode from the next cycle.
REQ-019 A cfg_we write during an active cycle SHALL NOT alter that cycle's latched cs or waits.
REQ-020 A request dropped in PRE SHALL still run to POST, then return to IDLE next cycle.

Reset
REQ-021 Reset SHALL force IDLE, counter 0 and all outputs 0 except buswait=1, asynchronously, including mid-cycle.
REQ-022 Reset SHALL load entry 0 as base F0000000h, limit FFFFFFFFh, cs 8, waits 3, wp 0, mode 11; entries 1..NREGIONS-1 SHALL reset with mode 00.

Verification
REQ-023 After reset, read to FFFF0000 -> start asserted 1 cycle, chipselect=8, buswait low 6 cycles after request (START 1 + PRE 4 + POST), busfault=0.
REQ-024 Read to 00100000 with no programmed entry -> next cycle busfault=1, fault_cause=01, buswait=0, chipselect=0; drop read -> IDLE, outputs clear.
REQ-025 Program entry 1 = 0..003FFFFF, cs 6, waits 0, wp 1, mode 01; write to 00000010 with map=0 -> fault cause 10; same read -> POST after 2 cycles in START/PRE, chipselect=6; same read with map=1 -> unmapped fault.
REQ-026 Entries 1 and 2 overlap at 00800000 with cs 5 and cs 4 -> chipselect=5.
REQ-027 Assert reset during PRE of a waits=3 write -> buswrite and chipselect drop immediately; after release, state is IDLE and a new read completes normally.
